// File: rtl/updown_count_ctrl_pkg.sv
// Shared types and constants for the up/down counter command sequencer.
package updown_count_ctrl_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_e;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   // One modulo-2**WIDTH step in the requested direction.
   function automatic logic [7:0] step_value(input logic [7:0] cur, input logic up);
      return (up == DIR_UP) ? cur + 8'd1 : cur - 8'd1;
   endfunction

endpackage

// File: rtl/updown_count_ctrl_if.sv
// Command channel between the host FSM and the sequencer: valid/ready plus payload.
interface updown_count_ctrl_if #(
   parameter int WIDTH   = 4,
   parameter int DWELL_W = 4
);
   logic               cmd_valid;
   logic               cmd_ready;
   logic               cmd_up;
   logic [WIDTH-1:0]   cmd_target;
   logic [DWELL_W-1:0] cmd_dwell;

   modport master (
      output cmd_valid,
      output cmd_up,
      output cmd_target,
      output cmd_dwell,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid,
      input  cmd_up,
      input  cmd_target,
      input  cmd_dwell,
      output cmd_ready
   );
endinterface

// File: rtl/updown_count_core.sv
// Counter datapath: +/-1 step per enabled cycle, modulo 2**WIDTH, with a
// registered wrap flag that is high only in the cycle the wrapped value appears.
module updown_count_core
   import updown_count_ctrl_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             en_i,
   input  logic             up_i,
   output logic [WIDTH-1:0] count_o,
   output logic             wrap_o
);

   logic [WIDTH-1:0] count_q, count_d;
   logic             wrap_q, wrap_d;

   // Next count and wrap flag; count holds and wrap clears when not stepping.
   always_comb begin
      count_d = count_q;
      wrap_d  = 1'b0;
      if (en_i) begin
         if (up_i == DIR_UP) begin
            count_d = count_q + WIDTH'(1);
            wrap_d  = (count_q == {WIDTH{1'b1}});
         end else begin
            count_d = count_q - WIDTH'(1);
            wrap_d  = (count_q == '0);
         end
      end
   end

   // Count and wrap registers, cleared asynchronously.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
         wrap_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         wrap_q  <= wrap_d;
      end
   end

   assign count_o = count_q;
   assign wrap_o  = wrap_q;

endmodule

// File: rtl/updown_count_ctrl.sv
// Command-driven sequencer: accepts one command (direction, target, dwell),
// steps the counter core toward the target every dwell+1 cycles, then pulses done.
module updown_count_ctrl
   import updown_count_ctrl_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int DWELL_W = 4
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   updown_count_ctrl_if.slave  cmd,
   input  logic                abort_i,
   output logic [WIDTH-1:0]    count_o,
   output logic                busy_o,
   output logic                done_o,
   output logic                wrap_o
);

   state_e             state_q, state_d;
   logic               up_q, up_d;
   logic [WIDTH-1:0]   target_q, target_d;
   logic [DWELL_W-1:0] dwell_q, dwell_d;
   logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
   logic               done_q;
   logic               step_en;
   logic [WIDTH-1:0]   count_w;
   logic [WIDTH-1:0]   step_val;
   logic [7:0]         step_wide;

   // Value the counter will hold after a step; used to detect arrival at target.
   assign step_wide = step_value(8'(count_w), up_q);
   assign step_val  = step_wide[WIDTH-1:0];

   // Next-state, command latch and dwell-counter logic.
   always_comb begin
      state_d     = state_q;
      up_d        = up_q;
      target_d    = target_q;
      dwell_d     = dwell_q;
      dwell_cnt_d = dwell_cnt_q;
      step_en     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (cmd.cmd_valid) begin
               up_d        = cmd.cmd_up;
               target_d    = cmd.cmd_target;
               dwell_d     = cmd.cmd_dwell;
               dwell_cnt_d = cmd.cmd_dwell;
               state_d     = (cmd.cmd_target == count_w) ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            // Abort wins over a step falling due in the same cycle.
            if (abort_i) begin
               state_d = S_IDLE;
            end else if (dwell_cnt_q != '0) begin
               dwell_cnt_d = dwell_cnt_q - DWELL_W'(1);
            end else begin
               step_en     = 1'b1;
               dwell_cnt_d = dwell_q;
               if (step_val == target_q) begin
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State, command latches, dwell counter and done pulse registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= S_IDLE;
         up_q        <= 1'b0;
         target_q    <= '0;
         dwell_q     <= '0;
         dwell_cnt_q <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         up_q        <= up_d;
         target_q    <= target_d;
         dwell_q     <= dwell_d;
         dwell_cnt_q <= dwell_cnt_d;
         done_q      <= (state_d == S_DONE);
      end
   end

   updown_count_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .en_i    (step_en),
      .up_i    (up_q),
      .count_o (count_w),
      .wrap_o  (wrap_o)
   );

   assign count_o       = count_w;
   assign done_o        = done_q;
   assign busy_o        = (state_q != S_IDLE);
   assign cmd.cmd_ready = (state_q == S_IDLE);

endmodule

// File: tb/tb_updown_count_ctrl.sv
// Directed bench for the up/down counter sequencer.
module tb_updown_count_ctrl;

   logic       clk;
   logic       rst_n;
   logic       abort;
   logic [3:0] count;
   logic       busy;
   logic       done;
   logic       wrap;

   int n_checks;
   int n_fail;

   updown_count_ctrl_if #(.WIDTH(4), .DWELL_W(4)) cmd_if ();

   updown_count_ctrl #(.WIDTH(4), .DWELL_W(4)) dut (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .cmd     (cmd_if),
      .abort_i (abort),
      .count_o (count),
      .busy_o  (busy),
      .done_o  (done),
      .wrap_o  (wrap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue a command and wait (bounded) until the controller is back in IDLE.
   task automatic run_cmd(input logic up, input logic [3:0] tgt, input logic [3:0] dw);
      cmd_if.cmd_valid  = 1'b1;
      cmd_if.cmd_up     = up;
      cmd_if.cmd_target = tgt;
      cmd_if.cmd_dwell  = dw;
      tick();
      cmd_if.cmd_valid = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (cmd_if.cmd_ready) break;
         tick();
      end
      n_checks++;
      if (cmd_if.cmd_ready !== 1'b1 || count !== tgt) begin
         n_fail++;
         $display("FAIL setup_run: ready=%b count=%h, required ready=1 count=%h", cmd_if.cmd_ready, count, tgt);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      abort = 1'b0;
      cmd_if.cmd_valid  = 1'b0;
      cmd_if.cmd_up     = 1'b0;
      cmd_if.cmd_target = 4'h0;
      cmd_if.cmd_dwell  = 4'h0;
      tick();
      tick();
      n_checks++;
      if ({count, done, wrap, busy, cmd_if.cmd_ready} !== {4'h0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL reset_state: count=%h done=%b wrap=%b busy=%b ready=%b, required 0 0 0 0 1",
                  count, done, wrap, busy, cmd_if.cmd_ready);
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_up_basic();
      logic [3:0] exp_cnt [4] = '{4'h1, 4'h2, 4'h3, 4'h3};
      logic       exp_dn  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
      logic       exp_rdy [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
      cmd_if.cmd_valid  = 1'b1;
      cmd_if.cmd_up     = 1'b1;
      cmd_if.cmd_target = 4'h3;
      cmd_if.cmd_dwell  = 4'h0;
      tick();
      cmd_if.cmd_valid = 1'b0;
      n_checks++;
      if ({count, busy, cmd_if.cmd_ready} !== {4'h0, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL up_accept: count=%h busy=%b ready=%b, required 0 1 0", count, busy, cmd_if.cmd_ready);
      end
      for (int k = 0; k < 4; k++) begin
         tick();
         n_checks++;
         if ({count, done, cmd_if.cmd_ready} !== {exp_cnt[k], exp_dn[k], exp_rdy[k]}) begin
            n_fail++;
            $display("FAIL up_edge%0d: count=%h done=%b ready=%b, required %h %b %b",
                     k + 1, count, done, cmd_if.cmd_ready, exp_cnt[k], exp_dn[k], exp_rdy[k]);
         end
      end
   endtask

   task automatic test_down_dwell();
      logic [3:0] exp_cnt;
      logic       exp_dn;
      logic       exp_busy;
      run_cmd(1'b0, 4'h2, 4'h0);
      cmd_if.cmd_valid  = 1'b1;
      cmd_if.cmd_up     = 1'b0;
      cmd_if.cmd_target = 4'h0;
      cmd_if.cmd_dwell  = 4'h2;
      tick();
      cmd_if.cmd_valid = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         tick();
         exp_cnt  = (k < 3) ? 4'h2 : (k < 6) ? 4'h1 : 4'h0;
         exp_dn   = (k == 6);
         exp_busy = (k <= 6);
         n_checks++;
         if ({count, done, busy} !== {exp_cnt, exp_dn, exp_busy}) begin
            n_fail++;
            $display("FAIL down_dwell_edge%0d: count=%h done=%b busy=%b, required %h %b %b",
                     k, count, done, busy, exp_cnt, exp_dn, exp_busy);
         end
      end
   endtask

   task automatic test_wrap();
      logic [3:0] exp_cnt [4] = '{4'hF, 4'h0, 4'h1, 4'h1};
      logic       exp_wr  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
      logic       exp_dn  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
      run_cmd(1'b1, 4'hE, 4'h0);
      cmd_if.cmd_valid  = 1'b1;
      cmd_if.cmd_up     = 1'b1;
      cmd_if.cmd_target = 4'h1;
      cmd_if.cmd_dwell  = 4'h0;
      tick();
      cmd_if.cmd_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         n_checks++;
         if ({count, wrap, done} !== {exp_cnt[k], exp_wr[k], exp_dn[k]}) begin
            n_fail++;
            $display("FAIL wrap_up_edge%0d: count=%h wrap=%b done=%b, required %h %b %b",
                     k + 1, count, wrap, done, exp_cnt[k], exp_wr[k], exp_dn[k]);
         end
      end
      // Downward wrap 0 -> F.
      cmd_if.cmd_valid  = 1'b1;
      cmd_if.cmd_up     = 1'b0;
      cmd_if.cmd_target = 4'hF;
      tick();
      cmd_if.cmd_valid = 1'b0;
      tick();
      n_checks++;
      if ({count, wrap} !== {4'h0, 1'b0}) begin
         n_fail++;
         $display("FAIL wrap_down_edge1: count=%h wrap=%b, required 0 0", count, wrap);
      end
      tick();
      n_checks++;
      if ({count, wrap, done} !== {4'hF, 1'b1, 1'b1}) begin
         n_fail++;
         $display("FAIL wrap_down_edge2: count=%h wrap=%b done=%b, required f 1 1", count, wrap, done);
      end
      tick();
   endtask

   task automatic test_zero_step();
      run_cmd(1'b1, 4'h5, 4'h0);
      cmd_if.cmd_valid  = 1'b1;
      cmd_if.cmd_up     = 1'b1;
      cmd_if.cmd_target = 4'h5;
      cmd_if.cmd_dwell  = 4'h3;
      tick();
      cmd_if.cmd_valid = 1'b0;
      n_checks++;
      if ({count, done, busy, cmd_if.cmd_ready} !== {4'h5, 1'b1, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL zero_step_done: count=%h done=%b busy=%b ready=%b, required 5 1 1 0",
                  count, done, busy, cmd_if.cmd_ready);
      end
      tick();
      n_checks++;
      if ({count, done, busy, cmd_if.cmd_ready} !== {4'h5, 1'b0, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL zero_step_idle: count=%h done=%b busy=%b ready=%b, required 5 0 0 1",
                  count, done, busy, cmd_if.cmd_ready);
      end
   endtask

   task automatic test_abort();
      logic seen_done;
      run_cmd(1'b0, 4'h4, 4'h0);
      seen_done = 1'b0;
      cmd_if.cmd_valid  = 1'b1;
      cmd_if.cmd_up     = 1'b1;
      cmd_if.cmd_target = 4'hA;
      cmd_if.cmd_dwell  = 4'h1;
      tick();
      cmd_if.cmd_valid = 1'b0;
      tick();
      seen_done = seen_done | done;
      abort = 1'b1;
      tick();
      abort = 1'b0;
      seen_done = seen_done | done;
      n_checks++;
      if ({count, busy, cmd_if.cmd_ready, wrap} !== {4'h4, 1'b0, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL abort_idle: count=%h busy=%b ready=%b wrap=%b, required 4 0 1 0",
                  count, busy, cmd_if.cmd_ready, wrap);
      end
      for (int k = 0; k < 4; k++) begin
         tick();
         seen_done = seen_done | done;
      end
      n_checks++;
      if ({count, seen_done} !== {4'h4, 1'b0}) begin
         n_fail++;
         $display("FAIL abort_hold: count=%h done_seen=%b, required 4 0", count, seen_done);
      end
   endtask

   task automatic test_async_reset();
      cmd_if.cmd_valid  = 1'b1;
      cmd_if.cmd_up     = 1'b1;
      cmd_if.cmd_target = 4'hC;
      cmd_if.cmd_dwell  = 4'h0;
      tick();
      // Held valid with a different target must be ignored while running.
      cmd_if.cmd_target = 4'h2;
      for (int k = 1; k <= 3; k++) begin
         tick();
         n_checks++;
         if ({count, busy} !== {4'(4 + k), 1'b1}) begin
            n_fail++;
            $display("FAIL held_cmd_run%0d: count=%h busy=%b, required %h 1", k, count, busy, 4'(4 + k));
         end
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({count, done, wrap, busy, cmd_if.cmd_ready} !== {4'h0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL async_reset: count=%h done=%b wrap=%b busy=%b ready=%b, required 0 0 0 0 1",
                  count, done, wrap, busy, cmd_if.cmd_ready);
      end
      tick();
      rst_n = 1'b1;
      tick();
      n_checks++;
      if ({count, busy} !== {4'h0, 1'b1}) begin
         n_fail++;
         $display("FAIL reaccept: count=%h busy=%b, required 0 1", count, busy);
      end
      cmd_if.cmd_valid = 1'b0;
      tick();
      tick();
      n_checks++;
      if ({count, done} !== {4'h2, 1'b1}) begin
         n_fail++;
         $display("FAIL reaccept_done: count=%h done=%b, required 2 1", count, done);
      end
      tick();
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_up_basic();
      test_down_dwell();
      test_wrap();
      test_zero_step();
      test_abort();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
